// File: rtl/prio_scan_pkg.sv
// Shared FSM state type and popcount helper for the priority scan encoder.
// Combinational helpers only; no latency or backpressure of their own.
package prio_scan_pkg;

   typedef enum logic {IDLE, EMIT} state_t;

   // Vectors are zero-extended to this width before counting.
   localparam int POP_W = 256;

   function automatic logic [8:0] popcount(input logic [POP_W-1:0] v);
      logic [8:0] n;
      n = '0;
      for (int i = 0; i < POP_W; i++) n = n + {8'd0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/prio_scan_encoder_pick.sv
// Find-first-set over a vector, lowest or highest bit first; returns index and one-hot mask.
// Purely combinational: zero latency, no backpressure.
module prio_pick
   import prio_scan_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] mask
);

   always_comb begin
      int  j;
      logic found;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      mask  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         j = MSB_FIRST ? (WIDTH - 1 - i) : i;
         if (!found && vec[j]) begin
            found   = 1'b1;
            idx     = IDX_W'(j);
            mask[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_scan_encoder.sv
// Accepts a request vector, then emits each set-bit index one beat per handshake; 1-cycle latency.
// Beats hold stable under out_ready low; no new vector accepted mid-burst. PRIO_SCAN_COUNT_EN adds out_count.
module prio_scan_encoder
   import prio_scan_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none
`ifdef PRIO_SCAN_COUNT_EN
   ,
   output logic [IDX_W:0]   out_count
`endif
);

   state_t           state;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] pick_mask;
   logic             none_q;
   logic             accept;
   logic             single;

   prio_pick #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_pick (
      .vec  (pend),
      .idx  (out_idx),
      .mask (pick_mask)
   );

   // At most one bit left means the current pick is the final beat.
   assign single    = ((pend & (pend - WIDTH'(1))) == '0);
   assign accept    = in_valid && in_ready;
   assign in_ready  = en && (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_last  = out_valid && single;
   assign out_none  = none_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pend   <= '0;
         none_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pend   <= in_vec;
                  none_q <= (in_vec == '0);
                  state  <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pend <= pend & ~pick_mask;
                  if (single) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PRIO_SCAN_COUNT_EN
   logic [POP_W-1:0] vec_wide;

   always_comb begin
      vec_wide              = '0;
      vec_wide[WIDTH-1:0]   = in_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      out_count <= '0;
      else if (accept) out_count <= (IDX_W + 1)'(popcount(vec_wide));
   end
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder: LSB-first and MSB-first instances share stimulus.
// Each is compared against an ordered-set-bit model of the burst it should emit.
module tb_prio_scan_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       out_ready;

   logic       r0_ready, r0_valid, r0_last, r0_none;
   logic [2:0] r0_idx;
   logic       r1_ready, r1_valid, r1_last, r1_none;
   logic [2:0] r1_idx;
`ifdef PRIO_SCAN_COUNT_EN
   logic [3:0] r0_count, r1_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(r0_ready),
      .in_vec(in_vec), .out_valid(r0_valid), .out_ready(out_ready), .out_idx(r0_idx),
      .out_last(r0_last), .out_none(r0_none)
`ifdef PRIO_SCAN_COUNT_EN
      , .out_count(r0_count)
`endif
   );

   prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(r1_ready),
      .in_vec(in_vec), .out_valid(r1_valid), .out_ready(out_ready), .out_idx(r1_idx),
      .out_last(r1_last), .out_none(r1_none)
`ifdef PRIO_SCAN_COUNT_EN
      , .out_count(r1_count)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Position of the k-th set bit counted from the chosen end; 0 for an empty vector.
   function automatic int kth(input logic [7:0] v, input int k, input bit msb);
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
         int p = msb ? 7 - i : i;
         if (v[p]) begin
            if (seen == k) return p;
            seen++;
         end
      end
      return 0;
   endfunction

   task automatic check_beat(input logic [7:0] v, input int k, input int nb);
      chk("valid0", int'(r0_valid), 1);
      chk("valid1", int'(r1_valid), 1);
      chk("idx0", int'(r0_idx), kth(v, k, 1'b0));
      chk("idx1", int'(r1_idx), kth(v, k, 1'b1));
      chk("last0", int'(r0_last), int'(k == nb - 1));
      chk("last1", int'(r1_last), int'(k == nb - 1));
      chk("none0", int'(r0_none), int'(v == 8'd0));
      chk("none1", int'(r1_none), int'(v == 8'd0));
`ifdef PRIO_SCAN_COUNT_EN
      chk("count0", int'(r0_count), $countones(v));
      chk("count1", int'(r1_count), $countones(v));
`endif
   endtask

   // Offers v, walks the whole burst, optionally stalls on beat stall_at, may change en mid-burst.
   task automatic run_burst(input logic [7:0] v, input int stall_at, input int stall_n,
                            input int en_mid);
      int tries = 0;
      int nb = ($countones(v) == 0) ? 1 : $countones(v);
      while (!(r0_ready && r1_ready) && tries < 20) begin
         @(posedge clk); #1;
         tries++;
      end
      chk("in_ready0_pre", int'(r0_ready), 1);
      chk("in_ready1_pre", int'(r1_ready), 1);
      in_valid = 1'b1;
      in_vec   = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_vec   = 8'($urandom);
      if (en_mid >= 0) en = en_mid[0];
      for (int k = 0; k < nb; k++) begin
         check_beat(v, k, nb);
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (stall_n) begin
               @(posedge clk); #1;
               check_beat(v, k, nb);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("valid0_end", int'(r0_valid), 0);
      chk("valid1_end", int'(r1_valid), 0);
      chk("in_ready0_end", int'(r0_ready), int'(en));
      chk("in_ready1_end", int'(r1_ready), int'(en));
   endtask

   initial begin
      logic [7:0] v;
      rst_n     = 1'b0;
      en        = 1'b1;
      in_valid  = 1'b0;
      in_vec    = 8'd0;
      out_ready = 1'b1;
      #12;
      chk("rst_valid0", int'(r0_valid), 0);
      chk("rst_idx0", int'(r0_idx), 0);
      chk("rst_last0", int'(r0_last), 0);
      chk("rst_none0", int'(r0_none), 0);
      chk("rst_valid1", int'(r1_valid), 0);
`ifdef PRIO_SCAN_COUNT_EN
      chk("rst_count0", int'(r0_count), 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed scenarios: mixed vector, single bit, zero vector, full vector with stall.
      run_burst(8'b1010_0100, -1, 0, -1);
      run_burst(8'b0001_0000, -1, 0, -1);
      run_burst(8'b0000_0000, -1, 0, -1);
      run_burst(8'b1111_1111, 1, 3, -1);

      // en low blocks acceptance entirely.
      en       = 1'b0;
      in_valid = 1'b1;
      in_vec   = 8'h0F;
      repeat (3) begin
         @(posedge clk); #1;
         chk("en0_ready0", int'(r0_ready), 0);
         chk("en0_valid0", int'(r0_valid), 0);
         chk("en0_valid1", int'(r1_valid), 0);
      end
      in_valid = 1'b0;
      en       = 1'b1;
      @(posedge clk); #1;

      // en dropped right after acceptance: burst still completes.
      run_burst(8'b0000_0110, -1, 0, 0);
      en = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a burst.
      in_valid = 1'b1;
      in_vec   = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_idx0", int'(r0_idx), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid0", int'(r0_valid), 0);
      chk("arst_valid1", int'(r1_valid), 0);
      chk("arst_idx0", int'(r0_idx), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready0", int'(r0_ready), 1);
      run_burst(8'b0100_1000, -1, 0, -1);

      // Random vectors with random stalls and en changes mid-burst.
      for (int t = 0; t < 40; t++) begin
         v = 8'($urandom);
         if ($urandom_range(0, 5) == 0) v = 8'd0;
         run_burst(v, int'($urandom_range(0, 9)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 1)));
         en = 1'b1;
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
